// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the banked memory block.
//               Holds the controller state encoding and the preload image
//               written into the low words after every reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int unsigned INIT_IMAGE_LEN = 4;

  localparam logic [15:0] INIT_IMAGE [INIT_IMAGE_LEN] = '{
    16'h02F0, 16'h22E8, 16'h02E2, 16'h22D1
  };

  // Preload word k; words past the end of the image are zero.
  function automatic logic [15:0] init_image_word(input int unsigned k);
    if (k < INIT_IMAGE_LEN) begin
      return INIT_IMAGE[k[1:0]];
    end
    return 16'h0000;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_ram.sv
// ============================================================================
// Module      : byte_lane_ram
// Description : One lane of the banked memory: a 2**ADDR_W-deep array of
//               DATA_W-bit entries with a write enable and a registered,
//               enable-gated read port. All updates on the falling clock edge.
// Ports       : clk       - clock (falling edge active)
//               rst       - asynchronous active-high reset (read register only)
//               i_we      - write enable for i_addr
//               i_re      - load read register from i_addr
//               i_addr    - entry address
//               i_wdata   - write data
//               o_rdata   - registered read data, held until the next i_re
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Storage is intentionally not reset: contents survive a reset.
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(negedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/banked_memory.sv
// ============================================================================
// Module      : banked_memory
// Description : Byte-addressable memory built from an even and an odd byte
//               lane. Preloads INIT_WORDS words after reset, then serves word
//               and byte reads/writes with a one-cycle read latency.
//               Misaligned word accesses are rejected with an err pulse.
// Ports       : clk       - clock, all state changes on the falling edge
//               proc_rst  - asynchronous active-high reset
//               req/we/byte_mode/addr/wdata - request, sampled while ready=1
//               rdata     - read data (held between reads)
//               rvalid    - one-cycle pulse, rdata valid / access rejected
//               ready     - request can be accepted this cycle
//               busy      - preload in progress
//               err       - one-cycle pulse on a misaligned word access
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_memory
  import mem_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 5,
  parameter int INIT_WORDS = 4
) (
  input  logic              clk,
  input  logic              proc_rst,
  input  logic              req,
  input  logic              we,
  input  logic              byte_mode,
  input  logic [ADDR_W:0]   addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int HALF_W = DATA_W / 2;
  localparam logic [ADDR_W:0] c_last_k =
    (ADDR_W+1)'((INIT_WORDS > 0) ? INIT_WORDS - 1 : 0);

  state_t              r_state, w_state_nxt;
  logic [ADDR_W:0]     r_k, w_k_nxt;
  logic                r_err, w_err_nxt;
  logic                r_rd_byte, w_rd_byte_nxt;
  logic                r_rd_odd, w_rd_odd_nxt;
  logic                w_we_even, w_we_odd, w_re;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [HALF_W-1:0]   w_wdata_even, w_wdata_odd;
  logic [HALF_W-1:0]   w_q_even, w_q_odd, w_q_sel;
  logic [DATA_W-1:0]   w_init_word;

  assign w_init_word = DATA_W'(init_image_word(32'(r_k)));

  always_ff @(negedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      r_state   <= ST_INIT;
      r_k       <= '0;
      r_err     <= 1'b0;
      r_rd_byte <= 1'b0;
      r_rd_odd  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_err     <= w_err_nxt;
      r_rd_byte <= w_rd_byte_nxt;
      r_rd_odd  <= w_rd_odd_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_err_nxt     = r_err;
    w_rd_byte_nxt = r_rd_byte;
    w_rd_odd_nxt  = r_rd_odd;
    w_we_even     = 1'b0;
    w_we_odd      = 1'b0;
    w_re          = 1'b0;
    w_ram_addr    = addr[ADDR_W:1];
    w_wdata_even  = wdata[HALF_W-1:0];
    // A byte write always takes the low half of wdata, whichever lane it hits.
    w_wdata_odd   = byte_mode ? wdata[HALF_W-1:0] : wdata[DATA_W-1:HALF_W];

    case (r_state)
      ST_INIT: begin
        w_ram_addr   = r_k[ADDR_W-1:0];
        w_wdata_even = w_init_word[HALF_W-1:0];
        w_wdata_odd  = w_init_word[DATA_W-1:HALF_W];
        if (INIT_WORDS == 0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_we_even = 1'b1;
          w_we_odd  = 1'b1;
          if (r_k == c_last_k) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_k_nxt = r_k + (ADDR_W+1)'(1);
          end
        end
      end

      ST_IDLE: begin
        if (req) begin
          w_err_nxt = 1'b0;
          if (!byte_mode && addr[0]) begin
            // Misaligned word access: no memory effect, rdata untouched.
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end else if (we) begin
            w_we_even = !byte_mode || !addr[0];
            w_we_odd  = !byte_mode ||  addr[0];
          end else begin
            w_re          = 1'b1;
            w_rd_byte_nxt = byte_mode;
            w_rd_odd_nxt  = addr[0];
            w_state_nxt   = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  byte_lane_ram #(.DATA_W(HALF_W), .ADDR_W(ADDR_W)) u_lane_even (
    .clk     (clk),
    .rst     (proc_rst),
    .i_we    (w_we_even),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wdata_even),
    .o_rdata (w_q_even)
  );

  byte_lane_ram #(.DATA_W(HALF_W), .ADDR_W(ADDR_W)) u_lane_odd (
    .clk     (clk),
    .rst     (proc_rst),
    .i_we    (w_we_odd),
    .i_re    (w_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wdata_odd),
    .o_rdata (w_q_odd)
  );

  // Lane outputs only change on an accepted read, and the access-type flags
  // are captured on the same edge, so rdata holds between reads.
  assign w_q_sel = r_rd_odd ? w_q_odd : w_q_even;
  assign rdata   = r_rd_byte ? {{HALF_W{w_q_sel[HALF_W-1]}}, w_q_sel}
                             : {w_q_odd, w_q_even};

  assign busy   = (r_state == ST_INIT);
  assign ready  = (r_state == ST_IDLE);
  assign rvalid = (r_state == ST_RESP);
  assign err    = (r_state == ST_RESP) && r_err;

endmodule

`default_nettype wire

// File: tb/tb_banked_memory.sv
// ============================================================================
// Module      : tb_banked_memory
// Description : Self-checking bench for banked_memory. A byte-array model of
//               memory predicts every response; directed scenarios cover
//               preload, lanes, misalignment, ignored requests and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_memory;

  logic        clk = 1'b0;
  logic        proc_rst = 1'b1;
  logic        req = 1'b0, we = 1'b0, byte_mode = 1'b0;
  logic [5:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        rvalid, ready, busy, err;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [15:0] IMG [4] = '{16'h02F0, 16'h22E8, 16'h02E2, 16'h22D1};

  logic [7:0]  bytes_m [64];
  logic [15:0] rd_m;

  banked_memory #(.DATA_W(16), .ADDR_W(5), .INIT_WORDS(4)) dut (
    .clk(clk), .proc_rst(proc_rst), .req(req), .we(we), .byte_mode(byte_mode),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rvalid(rvalid), .ready(ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    logic [15:0] w;
    rd_m = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      w = IMG[i];
      bytes_m[2*i]   = w[7:0];
      bytes_m[2*i+1] = w[15:8];
    end
  endtask

  // Memory seen as a flat byte array; a word is two consecutive bytes.
  task automatic ref_op(input logic a_we, a_bm, input logic [5:0] a,
                        input logic [15:0] wd,
                        output logic e_rv, e_err, output logic [15:0] e_rd);
    e_rv = 1'b0;
    e_err = 1'b0;
    if (!a_bm && a[0]) begin
      e_rv = 1'b1;
      e_err = 1'b1;
    end else if (a_we) begin
      bytes_m[a] = wd[7:0];
      if (!a_bm) bytes_m[a | 6'd1] = wd[15:8];
    end else begin
      e_rv = 1'b1;
      if (a_bm) rd_m = {{8{bytes_m[a][7]}}, bytes_m[a]};
      else      rd_m = {bytes_m[a | 6'd1], bytes_m[a]};
    end
    e_rd = rd_m;
  endtask

  // Called on a rising edge; waits (bounded) until the DUT is ready.
  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      n_cmp++;
      n_mis++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, want 1", ready, n);
    end
  endtask

  // Issue one request and sample the outputs one cycle after acceptance.
  task automatic access(input logic a_we, a_bm, input logic [5:0] a,
                        input logic [15:0] wd,
                        output logic o_rv, o_err, output logic [15:0] o_rd);
    wait_ready();
    req = 1'b1; we = a_we; byte_mode = a_bm; addr = a; wdata = wd;
    @(posedge clk);
    req = 1'b0;
    o_rv = rvalid; o_err = err; o_rd = rdata;
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    int cnt;
    #2;
    n_cmp++; if (busy !== 1'b1)    begin n_mis++; $display("FAIL rst_busy: got %b want 1", busy); end
    n_cmp++; if (ready !== 1'b0)   begin n_mis++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (rvalid !== 1'b0)  begin n_mis++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (err !== 1'b0)     begin n_mis++; $display("FAIL rst_err: got %b want 0", err); end
    n_cmp++; if (rdata !== 16'h0)  begin n_mis++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
    repeat (2) @(posedge clk);
    proc_rst = 1'b0;
    model_reset();
    count_busy(cnt);
    n_cmp++; if (cnt != 4)         begin n_mis++; $display("FAIL rst_busy_len: got %0d want 4", cnt); end
    n_cmp++; if (ready !== 1'b1)   begin n_mis++; $display("FAIL rst_ready_after: got %b want 1", ready); end
  endtask

  task automatic test_preload();
    logic rv, er, erv, eer;
    logic [15:0] rd, erd;
    for (int i = 0; i < 4; i++) begin
      ref_op(1'b0, 1'b0, 6'(2*i), 16'h0, erv, eer, erd);
      access(1'b0, 1'b0, 6'(2*i), 16'h0, rv, er, rd);
      n_cmp++; if (rv !== 1'b1) begin n_mis++; $display("FAIL preload_rvalid[%0d]: got %b want 1", i, rv); end
      n_cmp++; if (rd !== IMG[i]) begin n_mis++; $display("FAIL preload_rdata[%0d]: got %h want %h", i, rd, IMG[i]); end
      @(posedge clk);
      n_cmp++; if (rvalid !== 1'b0) begin n_mis++; $display("FAIL preload_pulse[%0d]: rvalid=%b want 0", i, rvalid); end
    end
  endtask

  task automatic test_byte_lanes();
    logic rv, er, erv, eer;
    logic [15:0] rd, erd;
    ref_op(1'b1, 1'b0, 6'd8, 16'hA5C3, erv, eer, erd);
    access(1'b1, 1'b0, 6'd8, 16'hA5C3, rv, er, rd);
    n_cmp++; if (rv !== 1'b0) begin n_mis++; $display("FAIL write_no_rvalid: got %b want 0", rv); end
    ref_op(1'b0, 1'b1, 6'd8, 16'h0, erv, eer, erd);
    access(1'b0, 1'b1, 6'd8, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'hFFC3) begin n_mis++; $display("FAIL byte_rd8: got %h want FFC3", rd); end
    ref_op(1'b0, 1'b1, 6'd9, 16'h0, erv, eer, erd);
    access(1'b0, 1'b1, 6'd9, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'hFFA5) begin n_mis++; $display("FAIL byte_rd9: got %h want FFA5", rd); end
    ref_op(1'b1, 1'b0, 6'd8, 16'h1234, erv, eer, erd);
    access(1'b1, 1'b0, 6'd8, 16'h1234, rv, er, rd);
    ref_op(1'b1, 1'b1, 6'd9, 16'hAB7F, erv, eer, erd);
    access(1'b1, 1'b1, 6'd9, 16'hAB7F, rv, er, rd);
    ref_op(1'b0, 1'b0, 6'd8, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd8, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h7F34) begin n_mis++; $display("FAIL byte_wr_odd: got %h want 7F34", rd); end
    ref_op(1'b1, 1'b1, 6'd8, 16'h5580, erv, eer, erd);
    access(1'b1, 1'b1, 6'd8, 16'h5580, rv, er, rd);
    ref_op(1'b0, 1'b0, 6'd8, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd8, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h7F80) begin n_mis++; $display("FAIL byte_wr_even: got %h want 7F80", rd); end
    ref_op(1'b0, 1'b1, 6'd9, 16'h0, erv, eer, erd);
    access(1'b0, 1'b1, 6'd9, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h007F) begin n_mis++; $display("FAIL byte_rd_pos: got %h want 007F", rd); end
  endtask

  task automatic test_misaligned();
    logic rv, er, erv, eer;
    logic [15:0] rd, erd;
    ref_op(1'b0, 1'b0, 6'd3, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd3, 16'h0, rv, er, rd);
    n_cmp++; if (er !== 1'b1)  begin n_mis++; $display("FAIL misrd_err: got %b want 1", er); end
    n_cmp++; if (rv !== 1'b1)  begin n_mis++; $display("FAIL misrd_rvalid: got %b want 1", rv); end
    n_cmp++; if (rd !== 16'h007F) begin n_mis++; $display("FAIL misrd_hold: got %h want 007F", rd); end
    ref_op(1'b1, 1'b0, 6'd3, 16'hBEEF, erv, eer, erd);
    access(1'b1, 1'b0, 6'd3, 16'hBEEF, rv, er, rd);
    n_cmp++; if (er !== 1'b1)  begin n_mis++; $display("FAIL miswr_err: got %b want 1", er); end
    @(posedge clk);
    n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL miswr_pulse: err=%b want 0", err); end
    ref_op(1'b0, 1'b0, 6'd2, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd2, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h22E8) begin n_mis++; $display("FAIL miswr_word1: got %h want 22E8", rd); end
  endtask

  task automatic test_ignore_in_resp();
    logic rv, er, erv, eer;
    logic [15:0] rd, erd;
    int rv_cnt = 0;
    ref_op(1'b0, 1'b0, 6'd4, 16'h0, erv, eer, erd);
    wait_ready();
    req = 1'b1; we = 1'b0; byte_mode = 1'b0; addr = 6'd4;
    @(posedge clk);
    if (rvalid === 1'b1) rv_cnt++;
    we = 1'b1; addr = 6'd8; wdata = 16'hDEAD;   // still requesting while in RESP
    @(posedge clk);
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (rvalid === 1'b1) rv_cnt++;
      @(posedge clk);
    end
    n_cmp++; if (rv_cnt != 1) begin n_mis++; $display("FAIL resp_rvalid_cnt: got %0d want 1", rv_cnt); end
    ref_op(1'b0, 1'b0, 6'd8, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd8, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL resp_ignored_wr: got %h want %h", rd, erd); end
  endtask

  task automatic test_reset_in_resp_and_init();
    logic rv, er, erv, eer;
    logic [15:0] rd, erd;
    int rv_cnt = 0;
    int cnt;
    ref_op(1'b1, 1'b0, 6'd12, 16'h1357, erv, eer, erd);
    access(1'b1, 1'b0, 6'd12, 16'h1357, rv, er, rd);
    access(1'b0, 1'b0, 6'd12, 16'h0, rv, er, rd);   // now in RESP
    proc_rst = 1'b1;
    #1;
    n_cmp++; if (rvalid !== 1'b0) begin n_mis++; $display("FAIL rst_resp_rvalid: got %b want 0", rvalid); end
    n_cmp++; if (rdata !== 16'h0) begin n_mis++; $display("FAIL rst_resp_rdata: got %h want 0000", rdata); end
    n_cmp++; if (busy !== 1'b1)   begin n_mis++; $display("FAIL rst_resp_busy: got %b want 1", busy); end
    model_reset();
    req = 1'b1; we = 1'b1; byte_mode = 1'b0; addr = 6'd0; wdata = 16'hDEAD;
    @(posedge clk);
    proc_rst = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      if (rvalid === 1'b1) rv_cnt++;
      @(posedge clk);
      cnt++;
    end
    req = 1'b0;
    n_cmp++; if (rv_cnt != 0) begin n_mis++; $display("FAIL init_rvalid: got %0d pulses want 0", rv_cnt); end
    ref_op(1'b0, 1'b0, 6'd0, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd0, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h02F0) begin n_mis++; $display("FAIL init_ignored_wr: got %h want 02F0", rd); end
    ref_op(1'b0, 1'b0, 6'd12, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd12, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h1357) begin n_mis++; $display("FAIL reset_retain: got %h want 1357", rd); end
  endtask

  task automatic test_reset_mid_init();
    logic rv, er, erv, eer;
    logic [15:0] rd, erd;
    int cnt;
    ref_op(1'b1, 1'b0, 6'd0, 16'h1111, erv, eer, erd);
    access(1'b1, 1'b0, 6'd0, 16'h1111, rv, er, rd);
    proc_rst = 1'b1;
    @(posedge clk);
    proc_rst = 1'b0;
    repeat (2) @(posedge clk);   // words 0 and 1 written; word 2 is next
    proc_rst = 1'b1;
    @(posedge clk);
    proc_rst = 1'b0;
    model_reset();
    count_busy(cnt);
    n_cmp++; if (cnt != 4) begin n_mis++; $display("FAIL midinit_busy_len: got %0d want 4", cnt); end
    ref_op(1'b0, 1'b0, 6'd0, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd0, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h02F0) begin n_mis++; $display("FAIL midinit_word0: got %h want 02F0", rd); end
    ref_op(1'b0, 1'b0, 6'd4, 16'h0, erv, eer, erd);
    access(1'b0, 1'b0, 6'd4, 16'h0, rv, er, rd);
    n_cmp++; if (rd !== 16'h02E2) begin n_mis++; $display("FAIL midinit_word2: got %h want 02E2", rd); end
  endtask

  task automatic test_random();
    logic rv, er, erv, eer, t_we, t_bm;
    logic [15:0] rd, erd, t_wd;
    logic [5:0] t_a;
    for (int w = 0; w < 32; w++) begin
      t_wd = 16'($urandom);
      ref_op(1'b1, 1'b0, 6'(2*w), t_wd, erv, eer, erd);
      access(1'b1, 1'b0, 6'(2*w), t_wd, rv, er, rd);
    end
    for (int i = 0; i < 150; i++) begin
      t_we = 1'($urandom);
      t_bm = 1'($urandom);
      t_a  = 6'($urandom_range(0, 63));
      t_wd = 16'($urandom);
      ref_op(t_we, t_bm, t_a, t_wd, erv, eer, erd);
      access(t_we, t_bm, t_a, t_wd, rv, er, rd);
      n_cmp++; if (rv !== erv) begin n_mis++; $display("FAIL rnd_rvalid[%0d] a=%0d: got %b want %b", i, t_a, rv, erv); end
      n_cmp++; if (er !== eer) begin n_mis++; $display("FAIL rnd_err[%0d] a=%0d: got %b want %b", i, t_a, er, eer); end
      n_cmp++; if (rd !== erd) begin n_mis++; $display("FAIL rnd_rdata[%0d] a=%0d: got %h want %h", i, t_a, rd, erd); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_byte_lanes();
    test_misaligned();
    test_ignore_in_resp();
    test_reset_in_resp_and_init();
    test_reset_mid_init();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
